// File: rtl/ser_pkg.sv
// Shared serial-link constants: FSM state codes, default geometry, frame bit order and parity polarity.
// Included by both the receive and the transmit side so the two cannot drift apart.
package ser_pkg;
  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] IDLE   = 3'd0;
  localparam logic [ST_W-1:0] START  = 3'd1;
  localparam logic [ST_W-1:0] DATA   = 3'd2;
  localparam logic [ST_W-1:0] PARITY = 3'd3;
  localparam logic [ST_W-1:0] STOP   = 3'd4;
  localparam logic [ST_W-1:0] BREAK  = 3'd5;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OVS    = 4;

  // Data bits travel LSB first; 0 selects even parity, 1 odd.
  localparam bit   LSB_FIRST  = 1'b1;
  localparam logic PARITY_ODD = 1'b0;

  // Expected parity bit for up to 16 data bits (zero-extension does not change it).
  function automatic logic par_of(input logic [15:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an idle-high async line; resets to 1 so reset never looks like a start bit.
// Latency 2 clk, no backpressure.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/ser_rx.sv
// Oversampling serial frame receiver: start, DATA_W bits LSB first, even parity, stop; one-cycle valid per frame.
// Latency 2+OVS/2+(DATA_W+2)*OVS clk from first low sample to the valid edge; no backpressure, words are overwritten.
module ser_rx
  import ser_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OVS    = DEF_OVS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [ST_W-1:0]   cs
);
  localparam int TW = (OVS > 2) ? $clog2(OVS) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              rx_s;
  logic [ST_W-1:0]   cs_q, ns;
  logic [TW-1:0]     tick;
  logic [BW-1:0]     bitcnt;
  logic [DATA_W-1:0] shreg;
  logic              par_s;
  logic              tick_mid, tick_end, last_bit;
  logic              tick_run, shift_en, par_en, done;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

  assign tick_mid = (tick == TW'(OVS/2 - 1));
  assign tick_end = (tick == TW'(OVS - 1));
  assign last_bit = (bitcnt == BW'(DATA_W - 1));
  assign cs       = cs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cs_q <= IDLE;
    else        cs_q <= ns;
  end

  always_comb begin
    ns = cs_q;
    case (cs_q)
      IDLE:   if (!rx_s) ns = START;
      START:  if (tick_mid) ns = rx_s ? IDLE : DATA;
      DATA:   if (tick_end && last_bit) ns = PARITY;
      PARITY: if (tick_end) ns = STOP;
      STOP:   if (tick_end) ns = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) ns = IDLE;
      default: ns = IDLE;
    endcase
  end

  always_comb begin
    busy     = (cs_q != IDLE);
    tick_run = (cs_q == START) || (cs_q == DATA) || (cs_q == PARITY) || (cs_q == STOP);
    shift_en = (cs_q == DATA) && tick_end;
    par_en   = (cs_q == PARITY) && tick_end;
    done     = (cs_q == STOP) && tick_end;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick   <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      par_s  <= 1'b0;
    end else begin
      // Tick restarts at every state change so each bit is sampled at a fixed offset.
      if (ns != cs_q || !tick_run || tick_end) tick <= '0;
      else                                     tick <= tick + 1'b1;
      if (cs_q == START)  bitcnt <= '0;
      else if (shift_en)  bitcnt <= bitcnt + 1'b1;
      if (shift_en) shreg <= (shreg >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
      if (par_en)   par_s <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
        data       <= shreg;
        parity_err <= (par_s != par_of(16'(shreg)));
        frame_err  <= !rx_s;
      end
    end
  end
endmodule
